// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// Optional checksum feature: define PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    DONE,
    ERR
  } loader_state_e;
`endif

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word packer: the first byte lands in bits [7:0].
// word/word_valid are combinational so the caller can register them on the 4th byte.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  // The three earlier bytes sit below the current one, oldest at the bottom
  assign word       = {byte_data, shift_q};
  assign word_valid = byte_valid && (byte_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {byte_data, shift_q[23:8]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes little-endian words to IMEM
// from address 0 and holds the core in reset until done. Optional: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter  int IMEM_DEPTH_WORDS = 256,
  localparam int ADDR_W           = $clog2(IMEM_DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam loader_state_e LOAD_END = CSUM;
`else
  localparam loader_state_e LOAD_END = DONE;
`endif

  loader_state_e     state, next_state;
  logic              ready_next;
  logic              xfer;
  logic              pk_valid, pk_clear, pk_word_valid;
  logic [31:0]       pk_word;
  logic [ADDR_W-1:0] word_idx, last_idx;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer     = byte_valid && byte_ready;
  assign pk_valid = xfer && ((state == LEN) || (state == DATA));
  assign pk_clear = !((state == LEN) || (state == DATA));

  // One packer serves both the 4-byte length header and the data words
  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (byte_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (load_req) next_state = LEN;
      LEN: begin
        if (pk_word_valid) begin
          if (pk_word == '0)                          next_state = LOAD_END;
          else if (pk_word > 32'(IMEM_DEPTH_WORDS))   next_state = ERR;
          else                                        next_state = DATA;
        end
      end
      DATA: if (pk_word_valid && (word_idx == last_idx)) next_state = LOAD_END;
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: if (xfer) next_state = (byte_data == csum) ? DONE : ERR;
`endif
      default: next_state = IDLE;
    endcase

    ready_next = (next_state == LEN) || (next_state == DATA);
`ifdef PROG_LOADER_CHECKSUM_EN
    ready_next = ready_next || (next_state == CSUM);
`endif
  end

  // Status outputs follow next_state so they are registered yet line up with the state;
  // cpu_rst_n only rises once DONE has been held for a full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready   <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_rst_n    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      word_idx     <= '0;
      last_idx     <= '0;
    end else begin
      byte_ready <= ready_next;
      load_done  <= (next_state == DONE);
      load_err   <= (next_state == ERR);
      cpu_rst_n  <= (state == DONE) && (next_state == DONE);
      imem_wr_en <= (state == DATA) && pk_word_valid;

      if (state == LEN) begin
        word_idx <= '0;
        if (pk_word_valid) last_idx <= ADDR_W'(pk_word - 32'd1);
      end else if ((state == DATA) && pk_word_valid) begin
        imem_wr_addr <= word_idx;
        imem_wr_data <= pk_word;
        word_idx     <= word_idx + ADDR_W'(1);
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR covers data bytes only; the header restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      csum <= '0;
    else if (state == LEN)           csum <= '0;
    else if ((state == DATA) && xfer) csum <= csum ^ byte_data;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; checksum cases run when
// PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b1;
  logic              load_req   = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data  = 8'h00;
  logic              byte_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;
  logic              cpu_rst_n;
  logic              load_done;
  logic              load_err;

  int tests  = 0;
  int errors = 0;

  int          wr_count = 0;
  logic [31:0] wr_addr_log [0:7];
  logic [31:0] wr_data_log [0:7];
  logic [7:0]  prog        [0:7];

  prog_loader #(.IMEM_DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_req     (load_req),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .cpu_rst_n    (cpu_rst_n),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  // Each cycle with the strobe high is logged, so a stretched strobe shows up as extra writes
  always @(negedge clk) begin
    if (imem_wr_en) begin
      if (wr_count < 8) begin
        wr_addr_log[wr_count] = 32'(imem_wr_addr);
        wr_data_log[wr_count] = imem_wr_data;
      end
      wr_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and returns #1 after the edge where it was accepted
  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    int guard;
    guard = 0;
    if (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'hEE;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput("byte_accept_timeout", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'hEE;
  endtask

  task automatic sendHeader(input logic [31:0] n);
    for (int i = 0; i < 4; i++) applyStimulus(n[8*i +: 8], 1'b0);
  endtask

  task automatic sendProgram(input bit gap);
    for (int i = 0; i < 8; i++) applyStimulus(prog[i], gap);
`ifdef PROG_LOADER_CHECKSUM_EN
    applyStimulus(8'hB0, gap);
`endif
  endtask

  task automatic startLoad();
    @(negedge clk);
    load_req = 1'b1;
    stepCycle();
    load_req = 1'b0;
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, "_wr_count"}, 32'(wr_count), 32'd2);
    checkOutput({tag, "_addr0"}, wr_addr_log[0], 32'd0);
    checkOutput({tag, "_data0"}, wr_data_log[0], 32'h00100513);
    checkOutput({tag, "_addr1"}, wr_addr_log[1], 32'd1);
    checkOutput({tag, "_data1"}, wr_data_log[1], 32'h00200593);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'h10; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h05; prog[6] = 8'h20; prog[7] = 8'h00;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("rst_load_done", 32'(load_done), 32'd0);
    checkOutput("rst_load_err", 32'(load_err), 32'd0);
    checkOutput("rst_wr_en", 32'(imem_wr_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("idle_byte_ready", 32'(byte_ready), 32'd0);

    // Two-word program at full rate
    wr_count = 0;
    startLoad();
    checkOutput("t1_len_ready", 32'(byte_ready), 32'd1);
    sendHeader(32'd2);
    sendProgram(1'b0);
`ifndef PROG_LOADER_CHECKSUM_EN
    checkOutput("t1_last_strobe", 32'(imem_wr_en), 32'd1);
`endif
    checkOutput("t1_load_done", 32'(load_done), 32'd1);
    checkOutput("t1_cpu_rst_entry", 32'(cpu_rst_n), 32'd0);
    checkOutput("t1_done_ready", 32'(byte_ready), 32'd0);
    stepCycle();
    checkOutput("t1_cpu_rst_rise", 32'(cpu_rst_n), 32'd1);
    checkOutput("t1_strobe_end", 32'(imem_wr_en), 32'd0);
    stepCycle();
    checkWrites("t1");

    // Same stream with byte_valid toggling
    wr_count = 0;
    startLoad();
    checkOutput("t2_cpu_rst_drop", 32'(cpu_rst_n), 32'd0);
    checkOutput("t2_done_clear", 32'(load_done), 32'd0);
    sendHeader(32'd2);
    sendProgram(1'b1);
    checkOutput("t2_load_done", 32'(load_done), 32'd1);
    stepCycle();
    stepCycle();
    checkWrites("t2");

    // Zero-length image
    wr_count = 0;
    startLoad();
    sendHeader(32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    checkOutput("t3_csum_ready", 32'(byte_ready), 32'd1);
    applyStimulus(8'h00, 1'b0);
`endif
    checkOutput("t3_load_done", 32'(load_done), 32'd1);
    repeat (3) stepCycle();
    checkOutput("t3_no_writes", 32'(wr_count), 32'd0);
    checkOutput("t3_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

    // Oversize header 257 > 256
    wr_count = 0;
    startLoad();
    sendHeader(32'd257);
    checkOutput("t4_load_err", 32'(load_err), 32'd1);
    checkOutput("t4_load_done", 32'(load_done), 32'd0);
    checkOutput("t4_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("t4_err_ready", 32'(byte_ready), 32'd0);
    repeat (2) stepCycle();
    checkOutput("t4_no_writes", 32'(wr_count), 32'd0);
    checkOutput("t4_err_held", 32'(load_err), 32'd1);
    startLoad();
    checkOutput("t4_err_clear", 32'(load_err), 32'd0);
    checkOutput("t4_restart_ready", 32'(byte_ready), 32'd1);

    // Reset mid-load after five data bytes, then a full reload
    sendHeader(32'd2);
    for (int i = 0; i < 5; i++) applyStimulus(prog[i], 1'b0);
    checkOutput("t5_partial_writes", 32'(wr_count), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_ready", 32'(byte_ready), 32'd0);
    checkOutput("t5_rst_wr_en", 32'(imem_wr_en), 32'd0);
    checkOutput("t5_rst_wr_addr", 32'(imem_wr_addr), 32'd0);
    checkOutput("t5_rst_wr_data", imem_wr_data, 32'd0);
    checkOutput("t5_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("t5_rst_done", 32'(load_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_count = 0;
    stepCycle();
    checkOutput("t5_idle_ready", 32'(byte_ready), 32'd0);
    startLoad();
    sendHeader(32'd2);
    sendProgram(1'b0);
    stepCycle();
    stepCycle();
    checkWrites("t5");
    checkOutput("t5_load_done", 32'(load_done), 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // One word, XOR of 13 05 10 00 is 06
    wr_count = 0;
    startLoad();
    sendHeader(32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(prog[i], 1'b0);
    stepCycle();
    checkOutput("t6_csum_ready", 32'(byte_ready), 32'd1);
    checkOutput("t6_not_done", 32'(load_done), 32'd0);
    applyStimulus(8'h06, 1'b0);
    checkOutput("t6_load_done", 32'(load_done), 32'd1);
    stepCycle();
    checkOutput("t6_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

    startLoad();
    sendHeader(32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(prog[i], 1'b0);
    applyStimulus(8'h07, 1'b0);
    checkOutput("t7_load_err", 32'(load_err), 32'd1);
    stepCycle();
    checkOutput("t7_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("t7_writes", 32'(wr_count), 32'd2);
    checkOutput("t7_data", wr_data_log[1], 32'h00100513);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
